// File: rtl/vram_writer.sv
// rtl/vram_writer.sv - VRAM write port and front/back buffer select for the LED matrix driver
// Turns pixel/fill/swap commands into back-buffer writes; swaps only at a display frame boundary.
module vram_writer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int BUF_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [4:0]            cmd_x,
  input  logic [4:0]            cmd_y,
  input  logic [5:0]            cmd_color,
  input  logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] vram_wraddress,
  output logic [DATA_WIDTH-1:0] vram_data,
  output logic                  vram_wren,
  output logic                  useSecondaryBuffer,
  output logic                  swap_pending
);

  localparam int CNT_W = $clog2(BUF_WORDS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [5:0]              fill_color, fill_color_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [DATA_WIDTH-1:0]   data_n;
  logic                    wren_n;
  logic                    use_n;
  logic                    pend_n;

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      cnt                <= '0;
      fill_color         <= '0;
      vram_wraddress     <= '0;
      vram_data          <= '0;
      vram_wren          <= 1'b0;
      useSecondaryBuffer <= 1'b0;
      swap_pending       <= 1'b0;
    end else begin
      state              <= state_n;
      cnt                <= cnt_n;
      fill_color         <= fill_color_n;
      vram_wraddress     <= addr_n;
      vram_data          <= data_n;
      vram_wren          <= wren_n;
      useSecondaryBuffer <= use_n;
      swap_pending       <= pend_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    fill_color_n = fill_color;
    addr_n       = vram_wraddress;
    data_n       = vram_data;
    wren_n       = 1'b0;
    use_n        = useSecondaryBuffer;
    pend_n       = swap_pending;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b00: begin
              wren_n = 1'b1;
              addr_n = ADDR_WIDTH'({~useSecondaryBuffer, cmd_y, cmd_x});
              data_n = DATA_WIDTH'(cmd_color);
            end
            2'b01: begin
              cnt_n        = '0;
              fill_color_n = cmd_color;
              state_n      = FILL;
            end
            2'b10: begin
              pend_n  = 1'b1;
              state_n = WAIT_SWAP;
            end
            default: ;
          endcase
        end
      end

      // The buffer select alone drives the address MSB, so the counter cannot spill into the front buffer.
      FILL: begin
        wren_n = 1'b1;
        addr_n = ADDR_WIDTH'({~useSecondaryBuffer, cnt});
        data_n = DATA_WIDTH'(fill_color);
        cnt_n  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(BUF_WORDS - 1)) begin
          state_n = IDLE;
        end
      end

      WAIT_SWAP: begin
        if (frame_done) begin
          use_n   = ~useSecondaryBuffer;
          pend_n  = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n      = IDLE;
        cnt_n        = '0;
        fill_color_n = '0;
        addr_n       = '0;
        data_n       = '0;
        use_n        = 1'b0;
        pend_n       = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vram_writer.sv
// tb/tb_vram_writer.sv - self-checking bench for vram_writer
// Vector table, directed corner sequences, then random commands against a VRAM-image model.
module tb_vram_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_x = '0;
  logic [4:0]  cmd_y = '0;
  logic [5:0]  cmd_color = '0;
  logic        frame_done = 1'b0;
  logic [10:0] vram_wraddress;
  logic [31:0] vram_data;
  logic        vram_wren;
  logic        useSecondaryBuffer;
  logic        swap_pending;

  vram_writer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
    .frame_done(frame_done), .vram_wraddress(vram_wraddress), .vram_data(vram_data),
    .vram_wren(vram_wren), .useSecondaryBuffer(useSecondaryBuffer), .swap_pending(swap_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int disp_wr_err = 0;
  logic [31:0] dut_mem [0:2047];
  logic [31:0] exp_mem [0:2047];

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  x;
    logic [4:0]  y;
    logic [5:0]  c;
    logic        ew;
    logic [10:0] ea;
    logic [31:0] ed;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] x, input logic [4:0] y,
                      input logic [5:0] c, input logic fd);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_x      = x;
    cmd_y      = y;
    cmd_color  = c;
    frame_done = fd;
    tick();
    cmd_valid  = 1'b0;
    frame_done = 1'b0;
  endtask

  // Every observed write lands in the DUT image and must target the non-displayed buffer.
  always @(negedge clk) begin
    if (rst && vram_wren) begin
      dut_mem[vram_wraddress] = vram_data;
      if (vram_wraddress[10] == useSecondaryBuffer) disp_wr_err++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int viol;
    logic exp_use;

    vecs[0] = '{2'd0, 5'd3,  5'd2,  6'h2A, 1'b1, 11'h443, 32'h2A};
    vecs[1] = '{2'd0, 5'd0,  5'd0,  6'h01, 1'b1, 11'h400, 32'h01};
    vecs[2] = '{2'd0, 5'd31, 5'd31, 6'h3F, 1'b1, 11'h7FF, 32'h3F};
    vecs[3] = '{2'd0, 5'd31, 5'd0,  6'h10, 1'b1, 11'h41F, 32'h10};
    vecs[4] = '{2'd0, 5'd0,  5'd31, 6'h05, 1'b1, 11'h7E0, 32'h05};
    vecs[5] = '{2'd3, 5'd7,  5'd7,  6'h3F, 1'b0, 11'h000, 32'h00};
    vecs[6] = '{2'd0, 5'd17, 5'd9,  6'h2C, 1'b1, 11'h531, 32'h2C};

    // Reset state
    repeat (3) tick();
    chk("rst_wren", vram_wren, 0);
    chk("rst_addr", vram_wraddress, 0);
    chk("rst_data", vram_data, 0);
    chk("rst_use", useSecondaryBuffer, 0);
    chk("rst_pend", swap_pending, 0);
    rst = 1'b1;
    tick();
    chk("rst_ready", cmd_ready, 1);

    // Pixel-write and reserved-op table
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].c, 1'b0);
      chk($sformatf("vec%0d_wren", i), vram_wren, vecs[i].ew);
      if (vecs[i].ew) begin
        chk($sformatf("vec%0d_addr", i), vram_wraddress, vecs[i].ea);
        chk($sformatf("vec%0d_data", i), vram_data, vecs[i].ed);
      end
      chk($sformatf("vec%0d_ready", i), cmd_ready, 1);
      tick();
      chk($sformatf("vec%0d_wren_off", i), vram_wren, 0);
    end

    // Back-to-back writes with cmd_valid held
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_y = 5'd5;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      cmd_x = 5'(i * 3 + 1);
      cmd_color = 6'(i);
      tick();
      if (vram_wren !== 1'b1 || vram_wraddress !== 11'(1024 + 5 * 32 + i * 3 + 1) ||
          vram_data !== 32'(i)) bad++;
    end
    cmd_valid = 1'b0;
    chk("b2b_writes_bad", bad, 0);
    tick();
    chk("b2b_wren_off", vram_wren, 0);

    // Fill of back buffer 1024..2047, frame_done mid-fill ignored
    send(2'd1, 5'd0, 5'd0, 6'h3F, 1'b0);
    chk("fill_ready_low", cmd_ready, 0);
    chk("fill_first_wren", vram_wren, 0);
    n = 0; bad = 0; viol = 0;
    for (int t = 0; t < 1100; t++) begin
      frame_done = (n == 300);
      tick();
      if (vram_wren) begin
        if (vram_wraddress !== 11'(1024 + n) || vram_data !== 32'h3F) bad++;
        n++;
        if (cmd_ready && n != 1024) viol++;
      end
      if (cmd_ready) break;
    end
    frame_done = 1'b0;
    chk("fill_count", n, 1024);
    chk("fill_addr_data_bad", bad, 0);
    chk("fill_ready_viol", viol, 0);
    chk("fill_ready_end", cmd_ready, 1);
    chk("fill_use", useSecondaryBuffer, 0);
    tick();
    chk("fill_wren_off", vram_wren, 0);

    // Swap with frame_done 50 cycles later
    send(2'd2, 5'd0, 5'd0, 6'h0, 1'b0);
    chk("swap_pend", swap_pending, 1);
    chk("swap_ready_low", cmd_ready, 0);
    bad = 0;
    for (int t = 0; t < 49; t++) begin
      tick();
      if (swap_pending !== 1'b1 || cmd_ready !== 1'b0 || useSecondaryBuffer !== 1'b0 ||
          vram_wren !== 1'b0) bad++;
    end
    chk("swap_wait_bad", bad, 0);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("swap_use", useSecondaryBuffer, 1);
    chk("swap_pend_clr", swap_pending, 0);
    chk("swap_ready", cmd_ready, 1);
    send(2'd0, 5'd0, 5'd0, 6'h15, 1'b0);
    chk("swap_wr_addr", vram_wraddress, 11'h000);
    chk("swap_wr_data", vram_data, 32'h15);
    tick();

    // Reset during fill at counter 500
    send(2'd1, 5'd0, 5'd0, 6'h0C, 1'b0);
    n = 0;
    for (int t = 0; t < 600; t++) begin
      tick();
      if (vram_wren && vram_wraddress == 11'd500) begin n = 1; break; end
    end
    chk("rstfill_reached", n, 1);
    #2 rst = 1'b0;
    #1;
    chk("rstfill_wren", vram_wren, 0);
    chk("rstfill_addr", vram_wraddress, 0);
    chk("rstfill_data", vram_data, 0);
    chk("rstfill_use", useSecondaryBuffer, 0);
    chk("rstfill_pend", swap_pending, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("rstfill_ready", cmd_ready, 1);
    chk("rstfill_use_after", useSecondaryBuffer, 0);
    chk("rstfill_wren_after", vram_wren, 0);

    // Swap accepted together with frame_done: waits for the next pulse
    send(2'd2, 5'd0, 5'd0, 6'h0, 1'b1);
    repeat (5) tick();
    chk("same_cyc_use", useSecondaryBuffer, 0);
    chk("same_cyc_pend", swap_pending, 1);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("same_cyc_toggle", useSecondaryBuffer, 1);

    // Random commands against a VRAM image model
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int a = 0; a < 2048; a++) begin
      dut_mem[a] = '0;
      exp_mem[a] = '0;
    end
    exp_use = 1'b0;
    bad = 0;
    for (int k = 0; k < 120; k++) begin
      int r;
      logic [4:0] rx, ry;
      logic [5:0] rc;
      logic [1:0] op;
      r  = $urandom_range(0, 99);
      rx = 5'($urandom);
      ry = 5'($urandom);
      rc = 6'($urandom);
      op = (r < 70) ? 2'd0 : (r < 76) ? 2'd1 : (r < 92) ? 2'd2 : 2'd3;
      send(op, rx, ry, rc, ($urandom_range(0, 3) == 0));
      if (op == 2'd0) begin
        exp_mem[(exp_use ? 0 : 1024) + ry * 32 + rx] = 32'(rc);
      end else if (op == 2'd1) begin
        for (int a = 0; a < 1024; a++) exp_mem[(exp_use ? 0 : 1024) + a] = 32'(rc);
        for (int t = 0; t < 1100 && !cmd_ready; t++) begin
          frame_done = ($urandom_range(0, 19) == 0);
          tick();
        end
        frame_done = 1'b0;
      end else if (op == 2'd2) begin
        repeat ($urandom_range(0, 8)) tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        exp_use = ~exp_use;
      end
      if (useSecondaryBuffer !== exp_use || cmd_ready !== 1'b1) bad++;
    end
    tick();
    tick();
    chk("rand_use_ready_bad", bad, 0);
    bad = 0;
    for (int a = 0; a < 2048; a++) if (dut_mem[a] !== exp_mem[a]) bad++;
    chk("rand_mem_mismatch_words", bad, 0);
    chk("displayed_buffer_writes", disp_wr_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
